lstm_gate_scheduler: RTL and testbench
======================================

# lstm_gate_scheduler

Top-level sequencer for one LSTM cell timestep loop. Shares the single SpMxV engine and activation unit among the four per-gate controllers (I, F, G, O), each of which has the I-gate-controller handshake: `idle` restart pulse in, level `done` out. After all four gates of a timestep complete, it launches the cell-state update unit, then repeats for `num_steps` timesteps. It sits between the host command interface and the gate controllers.

## Interface
Parameters:
- STEP_W, 8, width of timestep count
- TIMEOUT, 4096, max cycles waiting on any single gate or cell-update before error
- TO_W, 13, watchdog counter width (must hold TIMEOUT)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle command pulse; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE, no done
- num_steps  in  STEP_W  timestep count, latched on accepted start
- gate_done  in  4  per-gate done levels, bit0=I, bit1=F, bit2=G, bit3=O
- cell_done  in  1  cell-update completion (level or pulse)
- gate_idle  out  4  one-hot restart pulse to the selected gate controller
- spv_start  out  1  SpMxV engine start pulse, coincident with gate_idle
- gate_sel  out  2  index of gate owning SpMxV/activation datapath and BRAM write mux
- act_tanh  out  1  1 when gate_sel==2 (G uses tanh), else sigmoid
- cell_start  out  1  one-cycle pulse to cell-update unit
- busy  out  1  high in every state except IDLE
- step_cnt  out  STEP_W  current timestep index, 0-based
- done  out  1  one-cycle pulse after final timestep
- err  out  1  sticky watchdog error; cleared by accepted start or rst

## Operation
- States: IDLE, LAUNCH, WAIT_GATE, CELL, WAIT_CELL, FINISH, ERROR.
- IDLE: start=1 -> latch num_steps, step_cnt=0, gate_sel=0, err=0. If num_steps==0 -> FINISH, else LAUNCH. start in any other state ignored.
- LAUNCH (1 cycle): gate_idle[gate_sel]=1, spv_start=1; watchdog cleared; -> WAIT_GATE. gate_done is not sampled in LAUNCH (the gate clears its stale done on this edge).
- WAIT_GATE: watchdog increments each cycle. gate_done[gate_sel]=1 -> if gate_sel<3: gate_sel+1, -> LAUNCH; if gate_sel==3 -> CELL. Non-selected gate_done bits ignored. Watchdog reaching TIMEOUT-1 without done -> ERROR.
- CELL (1 cycle): cell_start=1, watchdog cleared; -> WAIT_CELL.
- WAIT_CELL: cell_done=1 -> if step_cnt==num_steps-1 -> FINISH; else step_cnt+1, gate_sel=0, -> LAUNCH. Same watchdog rule -> ERROR.
- FINISH (1 cycle): done=1; -> IDLE.
- ERROR: err=1, busy=1, all pulses 0; holds until abort (-> IDLE, err stays 1) or rst.
- abort=1 in any non-IDLE state -> IDLE next cycle; no done, no further pulses; gate_sel, step_cnt hold their values. abort has priority over all other transitions.
- gate_sel stays constant from LAUNCH through the matching done; it only changes on a done-driven transition.

## Timing
- All outputs registered; the pulse outputs (gate_idle, spv_start, cell_start, done) are high exactly while in their respective 1-cycle state.
- Reset values: state IDLE, gate_idle 0, spv_start 0, gate_sel 0, act_tanh 0, cell_start 0, busy 0, step_cnt 0, done 0, err 0.
- start high in cycle n -> gate_idle=0001 and spv_start in cycle n+1.
- gate_done[g] first high in cycle m -> next gate_idle (or cell_start) in cycle m+1: one cycle of scheduler overhead per handoff.
- cell_done high in cycle k -> gate_idle=0001 (next step) or done in cycle k+1.
- num_steps==0: done in cycle n+1, no gate_idle, no cell_start.
- Watchdog: error entered on the cycle after TIMEOUT cycles spent in a WAIT state with no done.
- Asserting rst mid-operation: all outputs to reset values immediately (asynchronous).

## Test plan
- num_steps=1, each gate_done raised 5 cycles after its gate_idle, cell_done 3 cycles after cell_start -> gate_idle sequence 0001,0010,0100,1000, act_tanh high only during gate 2, one cell_start, done exactly once; total cycles from start to done = 1+4*(5+1)+(3+1)=29 cycles ±1 per stated timing.
- num_steps=3 -> 12 gate_idle pulses, 3 cell_start, step_cnt 0->1->2, single done; stale gate_done level held high through LAUNCH not accepted.
- num_steps=0 -> done the cycle after start, busy high one cycle, no other pulses.
- gate_done[2] held high while gate_sel=0 -> ignored; only gate_done[0] advances.
- gate 1 never completes, TIMEOUT=16 -> err=1 after 16 WAIT_GATE cycles, state ERROR, no further pulses; abort -> IDLE with err=1; new start clears err.
- abort during WAIT_CELL of step 1 and rst asserted during LAUNCH -> IDLE, no done; rst forces all outputs to reset values asynchronously.

Source files
------------

// File: rtl/lstm_gate_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : lstm_gate_scheduler
//  Purpose  : Timestep sequencer for one LSTM cell. It lends the shared
//             SpMxV engine and activation unit to the I, F, G and O gate
//             controllers in turn. Once all four gates have finished it
//             starts the cell-state update. It repeats this for num_steps
//             timesteps.
//  Ports    : clk, rst         - clock (rising edge), async active-high reset
//             start, abort     - host command pulse / synchronous abort
//             num_steps        - timestep count, latched on accepted start
//             gate_done[3:0]   - per-gate done levels (I,F,G,O = bit0..3)
//             cell_done        - cell-update completion (level or pulse)
//             gate_idle[3:0]   - one-hot restart pulse to the selected gate
//             spv_start        - SpMxV start, coincident with gate_idle
//             gate_sel[1:0]    - gate owning the shared datapath
//             act_tanh         - tanh select (G gate), else sigmoid
//             cell_start       - cell-update start pulse
//             busy, step_cnt   - activity flag / current 0-based timestep
//             done, err        - completion pulse / sticky watchdog error
//  Revision : 1.0 - initial release
// ============================================================================
module lstm_gate_scheduler #(
  parameter int STEP_W  = 8,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [3:0]        gate_done,
  input  logic              cell_done,
  output logic [3:0]        gate_idle,
  output logic              spv_start,
  output logic [1:0]        gate_sel,
  output logic              act_tanh,
  output logic              cell_start,
  output logic              busy,
  output logic [STEP_W-1:0] step_cnt,
  output logic              done,
  output logic              err
);

  // Last watchdog count that is still allowed. With no done on that cycle,
  // the wait has lasted TIMEOUT cycles.
  localparam logic [TO_W-1:0] c_wdog_last = TO_W'(TIMEOUT - 1);
  localparam logic [1:0]      c_gate_g    = 2'd2;
  localparam logic [1:0]      c_gate_o    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_GATE = 3'd2,
    ST_CELL      = 3'd3,
    ST_WAIT_CELL = 3'd4,
    ST_FINISH    = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  state_t            r_state;
  logic [STEP_W-1:0] r_num_steps;
  logic [TO_W-1:0]   r_wdog;

  logic              w_gate_hit;
  logic              w_wdog_expired;
  logic              w_last_step;
  logic [1:0]        w_next_sel;
  logic [3:0]        w_next_idle;

  // Only the done bit of the gate that currently owns the datapath counts.
  // The other gates may still show stale done levels from earlier work.
  assign w_gate_hit     = gate_done[gate_sel];
  assign w_wdog_expired = (r_wdog == c_wdog_last);
  assign w_last_step    = (step_cnt == (r_num_steps - STEP_W'(1)));
  assign w_next_sel     = gate_sel + 2'd1;
  assign w_next_idle    = 4'b0001 << w_next_sel;

  // Every output is a register. Each pulse output is set on the transition
  // into its one-cycle state, so it is high exactly while in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_num_steps <= '0;
      r_wdog      <= '0;
      gate_idle   <= 4'b0000;
      spv_start   <= 1'b0;
      gate_sel    <= 2'd0;
      act_tanh    <= 1'b0;
      cell_start  <= 1'b0;
      busy        <= 1'b0;
      step_cnt    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Pulses are low unless a transition below raises them.
      gate_idle  <= 4'b0000;
      spv_start  <= 1'b0;
      cell_start <= 1'b0;
      done       <= 1'b0;

      if (abort && (r_state != ST_IDLE)) begin
        // Abort beats every other transition. gate_sel, step_cnt and err
        // keep their values so the host can see where the run stopped.
        r_state <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_num_steps <= num_steps;
              step_cnt    <= '0;
              gate_sel    <= 2'd0;
              act_tanh    <= 1'b0;
              err         <= 1'b0;
              r_wdog      <= '0;
              busy        <= 1'b1;
              if (num_steps == '0) begin
                r_state <= ST_FINISH;
                done    <= 1'b1;
              end else begin
                r_state   <= ST_LAUNCH;
                gate_idle <= 4'b0001;
                spv_start <= 1'b1;
              end
            end
          end

          ST_LAUNCH: begin
            // gate_done is ignored here. The gate drops its old done level
            // on this edge, so a level seen now is stale.
            r_wdog  <= '0;
            r_state <= ST_WAIT_GATE;
          end

          ST_WAIT_GATE: begin
            if (w_gate_hit) begin
              if (gate_sel == c_gate_o) begin
                r_state    <= ST_CELL;
                cell_start <= 1'b1;
              end else begin
                gate_sel  <= w_next_sel;
                act_tanh  <= (w_next_sel == c_gate_g);
                gate_idle <= w_next_idle;
                spv_start <= 1'b1;
                r_state   <= ST_LAUNCH;
              end
            end else if (w_wdog_expired) begin
              r_state <= ST_ERROR;
              err     <= 1'b1;
            end else begin
              r_wdog <= r_wdog + TO_W'(1);
            end
          end

          ST_CELL: begin
            r_wdog  <= '0;
            r_state <= ST_WAIT_CELL;
          end

          ST_WAIT_CELL: begin
            if (cell_done) begin
              if (w_last_step) begin
                r_state <= ST_FINISH;
                done    <= 1'b1;
              end else begin
                step_cnt  <= step_cnt + STEP_W'(1);
                gate_sel  <= 2'd0;
                act_tanh  <= 1'b0;
                gate_idle <= 4'b0001;
                spv_start <= 1'b1;
                r_state   <= ST_LAUNCH;
              end
            end else if (w_wdog_expired) begin
              r_state <= ST_ERROR;
              err     <= 1'b1;
            end else begin
              r_wdog <= r_wdog + TO_W'(1);
            end
          end

          ST_FINISH: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end

          ST_ERROR: begin
            // The scheduler stays here until abort or rst.
            r_state <= ST_ERROR;
          end

          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lstm_gate_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lstm_gate_scheduler
//  Purpose  : Self-checking bench for lstm_gate_scheduler. A behavioural
//             schedule model is compared with the DUT on every cycle, and
//             literal cycle and pulse counts are checked for each scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lstm_gate_scheduler;

  localparam int STEP_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort, cell_done;
  logic [STEP_W-1:0] num_steps;
  logic [3:0]        resp_done, extra_done;
  logic [3:0]        gate_idle;
  logic              spv_start, act_tanh, cell_start, busy, done, err;
  logic [1:0]        gate_sel;
  logic [STEP_W-1:0] step_cnt;
  wire  [3:0]        gate_done_w = resp_done | extra_done;

  lstm_gate_scheduler #(.STEP_W(STEP_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps),
    .gate_done(gate_done_w), .cell_done(cell_done), .gate_idle(gate_idle),
    .spv_start(spv_start), .gate_sel(gate_sel), .act_tanh(act_tanh),
    .cell_start(cell_start), .busy(busy), .step_cnt(step_cnt), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- gate / cell controller responders --------------------
  // A gate's done level stays up until it gets its next restart pulse. It
  // drops one cycle after that pulse, then rises gdly cycles after it.
  int gdly = 5, cdly = 3;
  logic [3:0] hang;
  int gcnt [4];
  int ccnt;
  initial begin
    resp_done = 4'b0000; cell_done = 1'b0; ccnt = 0;
    for (int g = 0; g < 4; g++) gcnt[g] = 0;
    forever begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        if (gate_idle[g]) gcnt[g] = hang[g] ? -1 : gdly;
        else if (gcnt[g] != 0) begin
          if (gcnt[g] > 0) gcnt[g]--;
          resp_done[g] = (gcnt[g] == 0);
        end
      end
      cell_done = 1'b0;
      if (cell_start) ccnt = cdly;
      else if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) cell_done = 1'b1;
      end
    end
  end

  // ---------------- behavioural schedule model ---------------------------
  // The model tracks which resource the schedule is waiting on (gate 0..3
  // or the cell unit), the number of cycles waited, and the step position.
  typedef enum {M_IDLE, M_KICK_GATE, M_ON_GATE, M_KICK_CELL, M_ON_CELL, M_FIN, M_STUCK} mph_t;
  mph_t       mph;
  int         m_n, m_waited, e_sel, e_step;
  logic [3:0] e_gate_idle;
  logic       e_spv, e_cell, e_busy, e_done, e_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mph = M_IDLE; m_n = 0; m_waited = 0; e_sel = 0; e_step = 0;
      e_gate_idle = 0; e_spv = 0; e_cell = 0; e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      e_gate_idle = 0; e_spv = 0; e_cell = 0; e_done = 0;
      if (abort && mph != M_IDLE) begin
        mph = M_IDLE; e_busy = 0;
      end else begin
        case (mph)
          M_IDLE: if (start) begin
            m_n = int'(num_steps); e_step = 0; e_sel = 0; e_err = 0; e_busy = 1;
            if (m_n == 0) begin mph = M_FIN; e_done = 1; end
            else begin mph = M_KICK_GATE; e_gate_idle = 4'b0001; e_spv = 1; end
          end
          M_KICK_GATE: begin mph = M_ON_GATE; m_waited = 0; end
          M_ON_GATE: begin
            m_waited++;
            if (gate_done_w[e_sel]) begin
              if (e_sel == 3) begin mph = M_KICK_CELL; e_cell = 1; end
              else begin
                e_sel++; mph = M_KICK_GATE; e_spv = 1;
                e_gate_idle = 4'(1 << e_sel);
              end
            end else if (m_waited == TIMEOUT) begin mph = M_STUCK; e_err = 1; end
          end
          M_KICK_CELL: begin mph = M_ON_CELL; m_waited = 0; end
          M_ON_CELL: begin
            m_waited++;
            if (cell_done) begin
              if (e_step == m_n - 1) begin mph = M_FIN; e_done = 1; end
              else begin
                e_step++; e_sel = 0; mph = M_KICK_GATE;
                e_gate_idle = 4'b0001; e_spv = 1;
              end
            end else if (m_waited == TIMEOUT) begin mph = M_STUCK; e_err = 1; end
          end
          M_FIN:   begin mph = M_IDLE; e_busy = 0; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare and event statistics ---------------
  logic chk_en = 1'b0;
  int n_idle, n_cell, n_done, n_busy, n_tanh, max_step, done_cyc;
  logic [3:0] seq [$];

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("gate_idle",  gate_idle,  e_gate_idle);
      chk("spv_start",  spv_start,  e_spv);
      chk("gate_sel",   gate_sel,   e_sel);
      chk("act_tanh",   act_tanh,   (e_sel == 2));
      chk("cell_start", cell_start, e_cell);
      chk("busy",       busy,       e_busy);
      chk("step_cnt",   step_cnt,   e_step);
      chk("done",       done,       e_done);
      chk("err",        err,        e_err);
      if (gate_idle != 0) begin n_idle++; seq.push_back(gate_idle); end
      if (cell_start) n_cell++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy) n_busy++;
      if (act_tanh) n_tanh++;
      if (int'(step_cnt) > max_step) max_step = int'(step_cnt);
    end
  end

  task automatic clear_stats();
    n_idle = 0; n_cell = 0; n_done = 0; n_busy = 0; n_tanh = 0;
    max_step = 0; done_cyc = -1; seq.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int start_cyc;
  task automatic go(input int n);
    num_steps = STEP_W'(n); start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int i;
    for (i = 0; i < maxc && !done; i++) tick();
    if (!done) chk({nm, "_timeout"}, 0, 1);
    tick(); tick();
  endtask

  // ---------------- directed scenarios -----------------------------------
  initial begin
    rst = 1'b1; start = 0; abort = 0; num_steps = 0; extra_done = 0; hang = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {gate_idle, spv_start, gate_sel, act_tanh, cell_start,
                          busy, step_cnt, done, err}, 0);
    rst = 1'b0; chk_en = 1'b1;
    tick();

    // One timestep, gate delay 5, cell delay 3: done 1+4*6+4 = 29 cycles later.
    clear_stats(); go(1); wait_done("t1", 100);
    chk("t1_latency", done_cyc - start_cyc, 29);
    chk("t1_idle_cnt", n_idle, 4);
    chk("t1_idle_seq", (seq.size() == 4) ? {seq[0], seq[1], seq[2], seq[3]} : 0, 16'h1248);
    chk("t1_cell_cnt", n_cell, 1);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_tanh_cycles", n_tanh, 6);

    // Three timesteps. Stale done levels from the earlier run, plus a forced
    // gate_done[2], are present while gate 0 is selected.
    clear_stats(); extra_done = 4'b0100; go(3);
    repeat (3) tick();
    extra_done = 4'b0000;
    wait_done("t2", 200);
    chk("t2_latency", done_cyc - start_cyc, 85);
    chk("t2_idle_cnt", n_idle, 12);
    chk("t2_cell_cnt", n_cell, 3);
    chk("t2_done_cnt", n_done, 1);
    chk("t2_max_step", max_step, 2);

    // Zero timesteps: done immediately, one busy cycle, no other pulses.
    clear_stats(); go(0); wait_done("t3", 10);
    chk("t3_latency", done_cyc - start_cyc, 1);
    chk("t3_busy_cycles", n_busy, 1);
    chk("t3_pulses", n_idle + n_cell, 0);

    // Gate 1 hangs: 16 waiting cycles, then ERROR (start + 1 + 6 + 1 + 16).
    clear_stats(); hang = 4'b0010; go(2);
    begin
      int i;
      for (i = 0; i < 100 && !err; i++) tick();
    end
    chk("t4_err_cycle", cyc - start_cyc, 24);
    chk("t4_err_busy", busy, 1);
    repeat (6) tick();
    chk("t4_idle_cnt", n_idle, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_err", err, 1);
    hang = 4'b0000;
    clear_stats(); go(0); wait_done("t4b", 10);
    chk("t4_err_cleared", err, 0);

    // Abort during the step-1 cell wait: no done, position held.
    clear_stats(); go(3);
    begin
      int i;
      for (i = 0; i < 200 && !(cell_start && step_cnt == 1); i++) tick();
      if (!(cell_start && step_cnt == 1)) chk("t5_reach_timeout", 0, 1);
    end
    tick(); abort = 1'b1; tick(); abort = 1'b0;
    repeat (10) tick();
    chk("t5_busy", busy, 0);
    chk("t5_step", step_cnt, 1);
    chk("t5_sel", gate_sel, 3);
    chk("t5_done_cnt", n_done, 0);

    // Asynchronous reset during LAUNCH, asserted mid-cycle.
    clear_stats(); go(1);
    chk("t6_in_launch", gate_idle, 4'b0001);
    #2 rst = 1'b1;
    #1 chk("t6_async_reset", {gate_idle, spv_start, gate_sel, act_tanh, cell_start,
                              busy, step_cnt, done, err}, 0);
    tick(); rst = 1'b0;
    repeat (10) tick();
    chk("t6_done_cnt", n_done, 0);
    chk("t6_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
